rr_sel21: RTL

Two-source round-robin selector with valid/ready handshakes that sits directly upstream of the `mux21` 2:1 multiplexer stage. It arbitrates between two data producers, registers the winning word, and drives the select line `s` that steers the downstream mux. It provides one registered output slot with full-throughput back-pressure. Fairness is guaranteed under continuous contention.

---
 rtl/rr_sel21.sv | 71 +++++++
 1 files changed

// File: rtl/rr_sel21.sv
// rr_sel21: two-source round-robin selector with a single registered output slot.
// Arbitrates between two valid/ready producers, captures the winning word into y,
// and drives s, the select line of the downstream 2:1 mux.
module rr_sel21 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d0_valid,
  input  logic [W-1:0] d0,
  output logic         d0_ready,
  input  logic         d1_valid,
  input  logic [W-1:0] d1,
  output logic         d1_ready,
  output logic         y_valid,
  output logic [W-1:0] y,
  input  logic         y_ready,
  output logic         s
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  logic   prio;
  logic   load;
  logic   grant0;
  logic   grant1;

  assign y_valid = (state == FULL);

  // Slot is free or being drained; a tie goes to the source the pointer names.
  always_comb begin
    load   = !y_valid || y_ready;
    grant0 = load && d0_valid && (!d1_valid || !prio);
    grant1 = load && d1_valid && (!d0_valid ||  prio);
  end

  // Readies are the grants, suppressed while reset is held.
  always_comb begin
    d0_ready = grant0 && !rst;
    d1_ready = grant1 && !rst;
  end

  // Slot state, captured word, select and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      y     <= '0;
      s     <= 1'b0;
      prio  <= 1'b0;
    end else if (load) begin
      if (grant0) begin
        y     <= d0;
        s     <= 1'b0;
        state <= FULL;
        prio  <= 1'b1;
      end else if (grant1) begin
        y     <= d1;
        s     <= 1'b1;
        state <= FULL;
        prio  <= 1'b0;
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule
